// File: rtl/id_pkg.sv
// Shared constants and latency type for the issue-stage scoreboard.
// Producer latencies are clamped into the range 1..MAX_LAT before use.
package id_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;
  localparam int MAX_LAT    = 4;
  localparam int LAT_W      = $clog2(MAX_LAT + 1);

  typedef logic [LAT_W-1:0] lat_t;

  // A zero latency still occupies the register for one advance; anything
  // above MAX_LAT is treated as MAX_LAT.
  function automatic lat_t clamp_lat(lat_t lat);
    if (lat == '0) return lat_t'(1);
    if (lat > lat_t'(MAX_LAT)) return lat_t'(MAX_LAT);
    return lat;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Single-operand resolution: x0 or a disabled read gives zero, otherwise the
// lowest-index matching forwarding bus wins over regfile data.
module id_fwd_mux
  import id_pkg::*;
#(
  parameter int NUM_FWD = 2
) (
  input  logic                          re,
  input  logic [REG_ADDR_W-1:0]         addr,
  input  logic [XLEN-1:0]               rf_data,
  input  logic [NUM_FWD-1:0]            fwd_we,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_wd,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_wdata,
  output logic [XLEN-1:0]               data
);

  always_comb begin
    data = rf_data;
    // Walk from the oldest bus down so the youngest match is applied last.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_wd[i*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
        data = fwd_wdata[i*XLEN +: XLEN];
      end
    end
    if (!re || (addr == '0)) begin
      data = '0;
    end
  end

endmodule

// File: rtl/id_scoreboard.sv
// Issue-stage scoreboard: per-register latency counters, RAW/WAW stall
// generation, operand forwarding and a saturating stall-cycle counter.
module id_scoreboard
  import id_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic [NUM_SRC-1:0]            src_re_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_i,
  input  logic [NUM_SRC*XLEN-1:0]       rf_data_i,
  input  logic                          wreg_i,
  input  logic [REG_ADDR_W-1:0]         wd_i,
  input  logic [LAT_W-1:0]              lat_i,
  input  logic                          kill_i,
  input  logic                          adv_i,
  input  logic [NUM_FWD-1:0]            fwd_we_i,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_wd_i,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_wdata_i,
  output logic [NUM_SRC*XLEN-1:0]       src_data_o,
  output logic                          stall_o,
  output logic [NUM_REGS-1:0]           busy_o,
  output logic [31:0]                   stall_cnt_o
);

  lat_t cnt [NUM_REGS];
  lat_t eff_lat;
  logic raw_hazard;
  logic waw_hazard;
  logic issue;

  assign eff_lat = clamp_lat(lat_i);

  always_comb begin
    raw_hazard = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (src_re_i[s] && (src_addr_i[s*REG_ADDR_W +: REG_ADDR_W] != '0) &&
          (cnt[src_addr_i[s*REG_ADDR_W +: REG_ADDR_W]] != '0)) begin
        raw_hazard = 1'b1;
      end
    end
  end

  // A new write may not retire before an older in-flight write to the same rd.
  assign waw_hazard = wreg_i && (wd_i != '0) && (cnt[wd_i] > eff_lat);
  assign stall_o    = valid_i && (raw_hazard || waw_hazard);
  assign issue      = valid_i && !stall_o && !kill_i;

  always_comb begin
    busy_o = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_o[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue && wreg_i && (wd_i == REG_ADDR_W'(r))) begin
          cnt[r] <= eff_lat;
        end else if (adv_i && (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - lat_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    id_fwd_mux #(
      .NUM_FWD(NUM_FWD)
    ) u_fwd_mux (
      .re       (src_re_i[s]),
      .addr     (src_addr_i[s*REG_ADDR_W +: REG_ADDR_W]),
      .rf_data  (rf_data_i[s*XLEN +: XLEN]),
      .fwd_we   (fwd_we_i),
      .fwd_wd   (fwd_wd_i),
      .fwd_wdata(fwd_wdata_i),
      .data     (src_data_o[s*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios plus a random
// phase, all compared against a cycle-level model of the scoreboard rules.
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [1:0]  src_re_i;
  logic [9:0]  src_addr_i;
  logic [63:0] rf_data_i;
  logic        wreg_i;
  logic [4:0]  wd_i;
  logic [2:0]  lat_i;
  logic        kill_i;
  logic        adv_i;
  logic [1:0]  fwd_we_i;
  logic [9:0]  fwd_wd_i;
  logic [63:0] fwd_wdata_i;
  logic [63:0] src_data_o;
  logic        stall_o;
  logic [31:0] busy_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int failures = 0;

  int          m_cnt [32];
  logic [31:0] m_scnt;

  always #5 clk = ~clk;

  id_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .src_re_i   (src_re_i),
    .src_addr_i (src_addr_i),
    .rf_data_i  (rf_data_i),
    .wreg_i     (wreg_i),
    .wd_i       (wd_i),
    .lat_i      (lat_i),
    .kill_i     (kill_i),
    .adv_i      (adv_i),
    .fwd_we_i   (fwd_we_i),
    .fwd_wd_i   (fwd_wd_i),
    .fwd_wdata_i(fwd_wdata_i),
    .src_data_o (src_data_o),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .stall_cnt_o(stall_cnt_o)
  );

  // ---------------- reference model ----------------
  function automatic int m_eff();
    int l;
    l = int'(lat_i);
    if (l == 0) return 1;
    if (l > 4) return 4;
    return l;
  endfunction

  function automatic bit m_stall();
    int a;
    if (!valid_i) return 1'b0;
    for (int s = 0; s < 2; s++) begin
      a = int'(src_addr_i[s*5 +: 5]);
      if (src_re_i[s] && a != 0 && m_cnt[a] != 0) return 1'b1;
    end
    if (wreg_i && wd_i != 5'd0 && m_cnt[wd_i] > m_eff()) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_operand(int s);
    logic [4:0] a;
    a = src_addr_i[s*5 +: 5];
    if (!src_re_i[s] || a == 5'd0) return 32'd0;
    for (int f = 0; f < 2; f++) begin
      if (fwd_we_i[f] && fwd_wd_i[f*5 +: 5] == a) return fwd_wdata_i[f*32 +: 32];
    end
    return rf_data_i[s*32 +: 32];
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 0; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_scnt = 32'd0;
  endtask

  // Advance one clock and apply the same cycle to the model.
  task automatic tick();
    bit st, iss;
    int e;
    st  = m_stall();
    e   = m_eff();
    iss = valid_i && !st && !kill_i;
    @(posedge clk);
    if (st && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
    for (int r = 1; r < 32; r++) if (adv_i && m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
    if (iss && wreg_i && wd_i != 5'd0) m_cnt[wd_i] = e;
    @(negedge clk);
  endtask

  task automatic set_instr(input bit v, input bit [1:0] re, input bit [4:0] a0,
                           input bit [4:0] a1, input bit w, input bit [4:0] wd,
                           input bit [2:0] lat, input bit kill, input bit adv);
    valid_i = v; src_re_i = re; src_addr_i = {a1, a0};
    wreg_i = w; wd_i = wd; lat_i = lat; kill_i = kill; adv_i = adv;
    fwd_we_i = 2'b00; fwd_wd_i = '0; fwd_wdata_i = '0;
    rf_data_i = {32'h1111_0001, 32'h2222_0000};
  endtask

  task automatic drain();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    set_instr(0, 2'b11, 5'd0, 5'd3, 0, 0, 0, 0, 0);
    m_reset();
    #3;
    checks++; if (busy_o !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    checks++; if (stall_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_stall_cnt got=%h exp=0", stall_cnt_o); end
    checks++; if (src_data_o !== {32'h1111_0001, 32'd0}) begin
      failures++; $display("FAIL reset_operands got=%h exp=%h", src_data_o, {32'h1111_0001, 32'd0}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    int n;
    set_instr(1, 0, 0, 0, 1, 5, 2, 0, 1);
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL load_use_issue got=%b exp=0", stall_o); end
    tick();
    set_instr(1, 2'b01, 5, 0, 0, 0, 0, 0, 1);
    #1;
    n = 0;
    while (stall_o === 1'b1 && n < 8) begin n++; tick(); #1; end
    checks++; if (n !== 2) begin failures++; $display("FAIL load_use_stall_cycles got=%0d exp=2", n); end
    fwd_we_i = 2'b01; fwd_wd_i = {5'd0, 5'd5}; fwd_wdata_i = {32'h0, 32'hDEAD_BEEF};
    #1;
    checks++; if (src_data_o[31:0] !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL load_use_fwd got=%h exp=deadbeef", src_data_o[31:0]); end
    checks++; if (stall_cnt_o !== m_scnt) begin
      failures++; $display("FAIL load_use_stall_cnt got=%0d exp=%0d", stall_cnt_o, m_scnt); end
    tick();
  endtask

  task automatic test_fwd_priority();
    set_instr(0, 2'b01, 7, 0, 0, 0, 0, 0, 0);
    rf_data_i[31:0] = 32'h0000_AAAA;
    fwd_wd_i = {5'd7, 5'd7}; fwd_wdata_i = {32'h22, 32'h11};
    fwd_we_i = 2'b11; #1;
    checks++; if (src_data_o[31:0] !== 32'h11) begin failures++; $display("FAIL fwd_both got=%h exp=11", src_data_o[31:0]); end
    fwd_we_i = 2'b10; #1;
    checks++; if (src_data_o[31:0] !== 32'h22) begin failures++; $display("FAIL fwd_only1 got=%h exp=22", src_data_o[31:0]); end
    fwd_we_i = 2'b00; #1;
    checks++; if (src_data_o[31:0] !== 32'h0000_AAAA) begin failures++; $display("FAIL fwd_none got=%h exp=aaaa", src_data_o[31:0]); end
    fwd_we_i = 2'b11; fwd_wd_i = {5'd7, 5'd6}; #1;
    checks++; if (src_data_o[31:0] !== 32'h22) begin failures++; $display("FAIL fwd_addr_miss0 got=%h exp=22", src_data_o[31:0]); end
    tick();
  endtask

  task automatic test_x0();
    set_instr(1, 0, 0, 0, 1, 0, 4, 0, 1);
    tick();
    set_instr(1, 2'b11, 0, 0, 0, 0, 0, 0, 1);
    fwd_we_i = 2'b01; fwd_wd_i = '0; fwd_wdata_i = {32'h0, 32'h55};
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b exp=0", stall_o); end
    checks++; if (busy_o[0] !== 1'b0) begin failures++; $display("FAIL x0_busy got=%b exp=0", busy_o[0]); end
    checks++; if (src_data_o !== 64'd0) begin failures++; $display("FAIL x0_operand got=%h exp=0", src_data_o); end
    tick();
  endtask

  task automatic test_waw();
    int n;
    drain();
    set_instr(1, 0, 0, 0, 1, 3, 3, 0, 1);
    tick();
    set_instr(1, 0, 0, 0, 1, 3, 1, 0, 0);
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL waw_stall got=%b exp=1", stall_o); end
    tick();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick(); tick();
    set_instr(1, 0, 0, 0, 1, 3, 2, 0, 1);
    #1;
    checks++; if (stall_o !== 1'b0 || busy_o[3] !== 1'b1) begin
      failures++; $display("FAIL waw_reissue got stall=%b busy3=%b exp stall=0 busy3=1", stall_o, busy_o[3]); end
    tick();
    set_instr(1, 2'b01, 3, 0, 0, 0, 0, 0, 1);
    #1;
    n = 0;
    while (stall_o === 1'b1 && n < 8) begin n++; tick(); #1; end
    checks++; if (n !== 2) begin failures++; $display("FAIL waw_override_cycles got=%0d exp=2", n); end
    checks++; if (stall_cnt_o !== m_scnt) begin
      failures++; $display("FAIL waw_stall_cnt got=%0d exp=%0d", stall_cnt_o, m_scnt); end
    tick();
  endtask

  task automatic test_hold_kill();
    drain();
    set_instr(1, 0, 0, 0, 1, 9, 3, 0, 1);
    tick();
    set_instr(1, 2'b01, 9, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (stall_o !== 1'b1 || busy_o[9] !== 1'b1) begin
        failures++; $display("FAIL hold_cycle%0d got stall=%b busy9=%b exp 1/1", i, stall_o, busy_o[9]); end
      tick();
    end
    kill_i = 1'b1; #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL kill_stall got=%b exp=1", stall_o); end
    tick();
    set_instr(1, 0, 0, 0, 1, 12, 2, 1, 0);
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL kill_issue_stall got=%b exp=0", stall_o); end
    tick();
    checks++; if (busy_o !== m_busy() || busy_o[12] !== 1'b0) begin
      failures++; $display("FAIL kill_busy got=%h exp=%h", busy_o, m_busy()); end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    set_instr(1, 0, 0, 0, 1, 9, 4, 0, 1);
    tick();
    set_instr(1, 2'b01, 9, 0, 0, 0, 0, 0, 1);
    #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%b exp=1", stall_o); end
    #1 rst = 1'b0;
    #1;
    m_reset();
    checks++; if (busy_o !== 32'd0 || stall_o !== 1'b0 || stall_cnt_o !== 32'd0) begin
      failures++; $display("FAIL rst_mid_clear got busy=%h stall=%b cnt=%0d exp 0/0/0", busy_o, stall_o, stall_cnt_o); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rst_release_stall got=%b exp=0", stall_o); end
    tick();
    checks++; if (stall_o !== 1'b0 || busy_o !== 32'd0) begin
      failures++; $display("FAIL rst_after_release got stall=%b busy=%h exp 0/0", stall_o, busy_o); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      valid_i     = ($urandom_range(0, 3) != 0);
      src_re_i    = 2'($urandom_range(0, 3));
      src_addr_i  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rf_data_i   = {$urandom, $urandom};
      wreg_i      = 1'($urandom_range(0, 1));
      wd_i        = 5'($urandom_range(0, 7));
      lat_i       = 3'($urandom_range(0, 7));
      kill_i      = ($urandom_range(0, 7) == 0);
      adv_i       = ($urandom_range(0, 3) != 0);
      fwd_we_i    = 2'($urandom_range(0, 3));
      fwd_wd_i    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_wdata_i = {$urandom, $urandom};
      #1;
      checks++; if (stall_o !== m_stall()) begin
        failures++; $display("FAIL rand_stall c=%0d got=%b exp=%b", c, stall_o, m_stall()); end
      checks++; if (src_data_o !== {m_operand(1), m_operand(0)}) begin
        failures++; $display("FAIL rand_operands c=%0d got=%h exp=%h", c, src_data_o, {m_operand(1), m_operand(0)}); end
      checks++; if (busy_o !== m_busy()) begin
        failures++; $display("FAIL rand_busy c=%0d got=%h exp=%h", c, busy_o, m_busy()); end
      checks++; if (stall_cnt_o !== m_scnt) begin
        failures++; $display("FAIL rand_stall_cnt c=%0d got=%0d exp=%0d", c, stall_cnt_o, m_scnt); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_x0();
    test_waw();
    test_hold_kill();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_scoreboard.md
ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameters: XLEN=32, data width; REG_ADDR_W=5, register address width; NUM_SRC=2, source operands per instruction; NUM_FWD=2, forwarding buses (index 0 = youngest); MAX_LAT=4, max producer latency; LAT_W=$clog2(MAX_LAT+1).
REQ-002 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  decoded instruction present.
- src_re_i  in  NUM_SRC  per-source read enable.
- src_addr_i  in  NUM_SRC*REG_ADDR_W  source register addresses.
- rf_data_i  in  NUM_SRC*XLEN  regfile read data.
- wreg_i  in  1  instruction writes rd.
- wd_i  in  REG_ADDR_W  destination register.
- lat_i  in  LAT_W  producer latency in advance cycles.
- kill_i  in  1  cancel this cycle's issue.
- adv_i  in  1  downstream pipeline advanced this cycle.
- fwd_we_i  in  NUM_FWD  forwarding bus valid.
- fwd_wd_i  in  NUM_FWD*REG_ADDR_W  forwarding destinations.
- fwd_wdata_i  in  NUM_FWD*XLEN  forwarding data.
- src_data_o  out  NUM_SRC*XLEN  resolved operands.
- stall_o  out  1  hazard stall request.
- busy_o  out  2**REG_ADDR_W  per-register pending flag.
- stall_cnt_o  out  32  saturating stall-cycle count.

Function
REQ-003 Scoreboard: one LAT_W-bit counter cnt[r] per register; r=0 never tracked, cnt[0]=0 always.
REQ-004 busy_o[r] = (cnt[r]!=0), combinational from state.
REQ-005 Operand resolution (combinational, per source): addr 0 or src_re_i=0 -> 0; else lowest-index fwd bus with fwd_we_i=1 and fwd_wd_i==addr; else rf_data_i.
REQ-006 RAW stall: stall_o=1 if valid_i and any enabled source with addr!=0 has cnt[addr]!=0.
REQ-007 WAW stall: stall_o=1 if valid_i, wreg_i, wd_i!=0 and cnt[wd_i] > eff_lat.
REQ-008 eff_lat = lat_i, except lat_i=0 -> 1 and lat_i>MAX_LAT -> MAX_LAT.
REQ-009 stall_o=0 whenever valid_i=0.
REQ-010 Issue event = valid_i & ~stall_o & ~kill_i.
REQ-011 Per cycle, each nonzero cnt[r] decrements by 1 when adv_i=1, else holds.
REQ-012 On issue with wreg_i=1 and wd_i!=0, cnt[wd_i] <= eff_lat next edge; this overrides the same-cycle decrement of that entry.
REQ-013 kill_i=1 blocks scoreboard update but does not change stall_o.
REQ-014 stall_cnt_o increments each cycle stall_o=1; saturates at 0xFFFF_FFFF.
REQ-015 Latency: scoreboard and counter updates visible one cycle after the causing edge; operand path zero-cycle.

Reset
REQ-016 rst=0 asynchronously clears all cnt[r] and stall_cnt_o; busy_o=0, stall_o=0 while valid_i=0.
REQ-017 Reset mid-operation discards all pending entries; no stall persists after release.
REQ-018 Combinational outputs remain defined during reset (src_data_o follows REQ-005).

Structure
REQ-019 Shared package id_pkg holds XLEN, REG_ADDR_W, NUM_REGS, MAX_LAT, LAT_W and the latency type.
REQ-020 One sub-module id_fwd_mux (single-operand resolution, REQ-005), instantiated NUM_SRC times.
REQ-021 Scoreboard counters, stall logic and stall counter reside in id_scoreboard top.

Verification
REQ-022 Load-use: issue wd=5 lat=2, next instr reads x5, adv_i=1 -> stall_o=1 for exactly 2 cycles, then src_data_o = fwd bus data 0xDEADBEEF.
REQ-023 Forward priority: fwd0 and fwd1 both target x7 with 0x11 and 0x22 -> src_data_o=0x11; only fwd1 -> 0x22; neither -> rf_data_i.
REQ-024 x0: write wd=0 lat=4 then read x0 -> no stall, busy_o[0]=0, operand 0.
REQ-025 WAW plus simultaneous update: cnt[3]=3, issue wd=3 lat=1 -> stall; cnt[3]=1 with adv_i=1, issue wd=3 lat=2 -> cnt[3]=2 next cycle.
REQ-026 Hold and kill: adv_i=0 for 5 cycles -> cnt held, stall persists; kill_i=1 on issue -> busy_o unchanged.
REQ-027 Reset mid-stall: cnt[9]=4, assert rst=0 -> busy_o=0 immediately, stall_cnt_o=0, no stall after release.
